arbitro_acceso_rtc: RTL
=======================

Name: arbitro_acceso_rtc

Overview:
- Schedules every access to the external RTC bus transaction engine, which owns the multiplexed address/data bus.
- Arbitrates between four requesters and one internal source:
  - requesters: RTC initialisation, date write, time write, countdown-timer (crono) write;
  - internal source: a periodic read timer.
- Issues one transaction at a time to the engine, waits for completion, then acknowledges the winner.
- Sits between the general control FSM and the bus engine.

Parameters:
PERIODO_LECTURA, 1000000, clock cycles between periodic read requests (min 4)
TIMEOUT_CICLOS, 4096, max cycles to wait for fin before aborting (min 2)

Ports:
reloj  in  1  system clock, all logic rising-edge
resetM  in  1  synchronous, active-high reset
req  in  4  level requests: [0] init, [1] date write, [2] time write, [3] crono write
hab_lectura  in  1  enables periodic reads
fin  in  1  single-cycle pulse from bus engine: transaction complete
inicio  out  1  single-cycle pulse: engine starts transaction cod_trans
cod_trans  out  3  0 INIT, 1 ESC_FECHA, 2 ESC_HORA, 3 ESC_CRONO, 4 LECTURA, held stable from LANZA through CIERRE
gnt  out  5  one-hot grant, bits [3:0] = req, bit 4 = periodic read; held LANZA..CIERRE
ack  out  4  single-cycle pulse per requester in CIERRE
sync  out  1  single-cycle pulse in CIERRE of a LECTURA completed without timeout
err_trans  out  1  single-cycle pulse in CIERRE when the transaction timed out
err_timeout  out  1  sticky timeout flag, cleared only by resetM
ini_hecho  out  1  set after first successful INIT, cleared by resetM

Behaviour:
- Reset (resetM=1 at an edge):
  - state=REPOSO;
  - all outputs 0, cod_trans=0;
  - read timer=0, lectura_pend=0, rr pointer=3, timeout counter=0.
- Reset mid-transaction aborts immediately. No ack is given. The engine must be reset by the same resetM.
- FSM states:
  - REPOSO: evaluate candidates each cycle. If a winner exists, latch its cod_trans and gnt, then go to LANZA.
  - LANZA: inicio=1 for exactly this cycle, timeout counter cleared, go to ESPERA.
  - ESPERA: counter increments each cycle.
    - fin=1 -> CIERRE (ok).
    - counter==TIMEOUT_CICLOS-1 without fin -> CIERRE (timeout).
    - fin in the same cycle as the terminal count counts as ok.
  - CIERRE: one cycle.
    - Always: pulse ack[winner] (if winner <4); clear gnt and go to REPOSO.
    - ok: INIT sets ini_hecho; LECTURA pulses sync.
    - timeout: pulse err_trans and set err_timeout. No sync, and ini_hecho is not set.
- fin outside ESPERA is ignored.
- Minimum latency: req sampled high in REPOSO at edge N -> inicio high in cycle N+1. fin at edge M -> ack at M+1, and REPOSO is re-entered at M+2.
- Requester contract: hold req until ack, and deassert on the edge where ack=1. A req still high in REPOSO is a new request.
- Priority, evaluated in REPOSO:
  1. req[0] (INIT) always wins.
  2. Writes req[1..3] use round-robin. The search starts at index rr+1 and wraps 3->1. rr updates to the winner index in CIERRE.
  3. Periodic read is lowest priority.
- Until ini_hecho=1, only INIT is eligible. Writes and reads are masked, but lectura_pend still accumulates.
- Read timer:
  - free-running 0..PERIODO_LECTURA-1 while hab_lectura=1; held at 0 when hab_lectura=0;
  - terminal count sets lectura_pend;
  - a further terminal count while pending is dropped (no queueing);
  - lectura_pend clears when LECTURA is latched in REPOSO;
  - hab_lectura=0 also clears lectura_pend.
- Simultaneous events: a terminal count in the same cycle LECTURA is latched leaves lectura_pend=1.
- Widths: timer ceil(log2(PERIODO_LECTURA)) bits, timeout counter ceil(log2(TIMEOUT_CICLOS)) bits, no overflow possible.

Decomposition:
- Package rtc_arb_pkg:
  - state encodings REPOSO/LANZA/ESPERA/CIERRE;
  - cod_trans constants COD_INIT..COD_LECTURA;
  - requester index constants.
- Sub-module temporizador_lectura:
  - contains the periodic counter and lectura_pend;
  - ports: reloj, resetM, hab, consumir, pend.

Test Plan (PERIODO_LECTURA=20, TIMEOUT_CICLOS=16):
1. Reset then req=4'b0110 with ini_hecho=0 -> no inicio. req[0]=1 -> inicio, cod_trans=0. fin 5 cycles later -> ack=4'b0001 next cycle, ini_hecho=1.
2. After init, req=4'b1110 held with fin 3 cycles after each inicio. Grant order is cod_trans 1,2,3,1. Each ack is one cycle, and inicio->inicio spacing is 6 cycles.
3. hab_lectura=1, no req -> inicio with cod_trans=4 every ~20 cycles. Each fin produces sync=1 for one cycle and gnt=5'b10000.
4. fin never returned after a cod_trans=2 inicio -> after 16 ESPERA cycles, CIERRE pulses ack[2]=1 and err_trans=1, err_timeout stays 1, and sync stays 0.
5. req[3] and a pending read in REPOSO simultaneously -> cod_trans=3 first, then LECTURA. A terminal count during the write leaves only one read.
6. resetM=1 for one cycle during ESPERA -> next cycle all outputs 0, ini_hecho=0, and no ack is issued. A later fin is ignored.

Source files
------------

// File: rtl/rtc_arb_pkg.sv
// Shared definitions for the RTC bus access arbiter: FSM states, transaction
// codes, requester indices and the small selection helpers.
package rtc_arb_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    LANZA  = 2'd1,
    ESPERA = 2'd2,
    CIERRE = 2'd3
  } estado_t;

  localparam logic [2:0] COD_INIT      = 3'd0;
  localparam logic [2:0] COD_ESC_FECHA = 3'd1;
  localparam logic [2:0] COD_ESC_HORA  = 3'd2;
  localparam logic [2:0] COD_ESC_CRONO = 3'd3;
  localparam logic [2:0] COD_LECTURA   = 3'd4;

  localparam int IDX_INIT    = 0;
  localparam int IDX_FECHA   = 1;
  localparam int IDX_HORA    = 2;
  localparam int IDX_CRONO   = 3;
  localparam int IDX_LECTURA = 4;

  // Transaction code equals requester index, so the grant is a one-hot of the code.
  function automatic logic [4:0] gnt_de_cod(input logic [2:0] cod);
    logic [4:0] g;
    case (cod)
      COD_INIT:      g = 5'b00001;
      COD_ESC_FECHA: g = 5'b00010;
      COD_ESC_HORA:  g = 5'b00100;
      COD_ESC_CRONO: g = 5'b01000;
      COD_LECTURA:   g = 5'b10000;
      default:       g = 5'b00000;
    endcase
    return g;
  endfunction

  function automatic logic es_escritura(input logic [2:0] cod);
    return (cod == COD_ESC_FECHA) || (cod == COD_ESC_HORA) || (cod == COD_ESC_CRONO);
  endfunction

  // Round-robin over writes 1..3, search starts after the last winner; 0 means none.
  function automatic logic [2:0] rr_ganador(input logic [3:1] w, input logic [1:0] rr);
    logic [2:0] g;
    g = 3'd0;
    case (rr)
      2'd1: begin
        if (w[2])      g = 3'd2;
        else if (w[3]) g = 3'd3;
        else if (w[1]) g = 3'd1;
        else           g = 3'd0;
      end
      2'd2: begin
        if (w[3])      g = 3'd3;
        else if (w[1]) g = 3'd1;
        else if (w[2]) g = 3'd2;
        else           g = 3'd0;
      end
      default: begin
        if (w[1])      g = 3'd1;
        else if (w[2]) g = 3'd2;
        else if (w[3]) g = 3'd3;
        else           g = 3'd0;
      end
    endcase
    return g;
  endfunction

endpackage

// File: rtl/arbitro_acceso_rtc_temporizador_lectura.sv
// Periodic read timer: free-running while enabled, raises a single
// non-queued pending flag at each terminal count.
module temporizador_lectura #(
  parameter int PERIODO = 1000000
) (
  input  logic reloj,
  input  logic resetM,
  input  logic hab,
  input  logic consumir,
  output logic pend
);

  localparam int              W   = $clog2(PERIODO);
  localparam logic [W-1:0]    FIN = W'(PERIODO - 1);

  logic [W-1:0] r_cnt;
  logic         r_pend;
  logic         w_tc;

  assign w_tc = hab && (r_cnt == FIN);
  assign pend = r_pend;

  // Counter and pending flag; a terminal count wins over a same-cycle consume.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else if (!hab) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + W'(1);
      if (w_tc)          r_pend <= 1'b1;
      else if (consumir) r_pend <= 1'b0;
      else               r_pend <= r_pend;
    end
  end

endmodule

// File: rtl/arbitro_acceso_rtc.sv
// Arbiter that serialises INIT, write and periodic-read transactions onto the
// RTC bus engine, one at a time, with timeout supervision.
module arbitro_acceso_rtc
  import rtc_arb_pkg::*;
#(
  parameter int PERIODO_LECTURA = 1000000,
  parameter int TIMEOUT_CICLOS  = 4096
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [3:0] req,
  input  logic       hab_lectura,
  input  logic       fin,
  output logic       inicio,
  output logic [2:0] cod_trans,
  output logic [4:0] gnt,
  output logic [3:0] ack,
  output logic       sync,
  output logic       err_trans,
  output logic       err_timeout,
  output logic       ini_hecho
);

  localparam int              TO_W   = $clog2(TIMEOUT_CICLOS);
  localparam logic [TO_W-1:0] TO_FIN = TO_W'(TIMEOUT_CICLOS - 1);

  estado_t         r_estado;
  logic [2:0]      r_cod;
  logic [4:0]      r_gnt;
  logic            r_inicio;
  logic [3:0]      r_ack;
  logic            r_sync;
  logic            r_err_trans;
  logic            r_err_timeout;
  logic            r_ini_hecho;
  logic [1:0]      r_rr;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_pend;
  logic            w_consumir;
  logic            w_hay;
  logic [2:0]      w_gan;
  logic [2:0]      w_rr;
  logic            w_ok;

  temporizador_lectura #(.PERIODO(PERIODO_LECTURA)) u_temporizador (
    .reloj    (reloj),
    .resetM   (resetM),
    .hab      (hab_lectura),
    .consumir (w_consumir),
    .pend     (w_pend)
  );

  // Candidate selection: INIT first, then round-robin writes, then the read.
  always_comb begin
    w_hay = 1'b0;
    w_gan = COD_INIT;
    w_rr  = rr_ganador(req[3:1], r_rr);
    if (req[IDX_INIT]) begin
      w_hay = 1'b1;
      w_gan = COD_INIT;
    end else if (r_ini_hecho && (w_rr != 3'd0)) begin
      w_hay = 1'b1;
      w_gan = w_rr;
    end else if (r_ini_hecho && w_pend) begin
      w_hay = 1'b1;
      w_gan = COD_LECTURA;
    end else begin
      w_hay = 1'b0;
      w_gan = COD_INIT;
    end
  end

  assign w_consumir = (r_estado == REPOSO) && w_hay && (w_gan == COD_LECTURA);
  assign w_ok       = fin;

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_estado      <= REPOSO;
      r_cod         <= COD_INIT;
      r_gnt         <= 5'b00000;
      r_inicio      <= 1'b0;
      r_ack         <= 4'b0000;
      r_sync        <= 1'b0;
      r_err_trans   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_ini_hecho   <= 1'b0;
      r_rr          <= 2'd3;
      r_to_cnt      <= '0;
    end else begin
      r_inicio    <= 1'b0;
      r_ack       <= 4'b0000;
      r_sync      <= 1'b0;
      r_err_trans <= 1'b0;
      case (r_estado)
        REPOSO: begin
          if (w_hay) begin
            r_cod    <= w_gan;
            r_gnt    <= gnt_de_cod(w_gan);
            r_inicio <= 1'b1;
            r_estado <= LANZA;
          end else begin
            r_estado <= REPOSO;
          end
        end
        LANZA: begin
          r_to_cnt <= '0;
          r_estado <= ESPERA;
        end
        ESPERA: begin
          if (w_ok || (r_to_cnt == TO_FIN)) begin
            // Completion pulses are registered here so they show during CIERRE.
            r_estado <= CIERRE;
            if (r_cod != COD_LECTURA) r_ack <= 4'b0001 << r_cod[1:0];
            if (es_escritura(r_cod))  r_rr  <= r_cod[1:0];
            if (w_ok) begin
              if (r_cod == COD_INIT)    r_ini_hecho <= 1'b1;
              if (r_cod == COD_LECTURA) r_sync      <= 1'b1;
            end else begin
              r_err_trans   <= 1'b1;
              r_err_timeout <= 1'b1;
            end
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        CIERRE: begin
          r_gnt    <= 5'b00000;
          r_cod    <= COD_INIT;
          r_estado <= REPOSO;
        end
        default: begin
          r_estado <= REPOSO;
        end
      endcase
    end
  end

  assign inicio      = r_inicio;
  assign cod_trans   = r_cod;
  assign gnt         = r_gnt;
  assign ack         = r_ack;
  assign sync        = r_sync;
  assign err_trans   = r_err_trans;
  assign err_timeout = r_err_timeout;
  assign ini_hecho   = r_ini_hecho;

endmodule
